// File: rtl/debounce_filter.sv
// -----------------------------------------------------------------------------
// debounce_filter
//
// Multi-channel debounce filter for switches, buttons and other noisy
// asynchronous inputs. Each channel passes through a SYNC_STAGES-deep
// synchroniser. It is then qualified by a stability counter. The filtered
// level changes only after the synchronised input has differed from it for
// DEPTH consecutive qualified samples. Every accepted change comes with a
// one-cycle rise or fall pulse.
//
// Optional feature, enabled by defining DEBOUNCE_GLITCH_CNT_EN:
//     Adds a saturating 8-bit count of rejected transitions, plus a clear
//     input. A rejected transition is a run of differing samples that is cut
//     short by the matching level.
//
// Parameters
//     CHANNELS    : number of independent channels (1..32)
//     DEPTH       : consecutive qualified samples needed to accept a level (>=1)
//     SYNC_STAGES : synchroniser flops per channel (>=1)
//
// Ports
//     clock       in   1         rising-edge clock
//     reset       in   1         synchronous, active-low reset
//     sig_in      in   CHANNELS  raw asynchronous inputs
//     sample_en   in   1         qualification strobe (tie high for every clock)
//     sig_out     out  CHANNELS  filtered levels (registered)
//     rise        out  CHANNELS  one-cycle pulse when sig_out[i] goes 0->1
//     fall        out  CHANNELS  one-cycle pulse when sig_out[i] goes 1->0
//     glitch_clr  in   1         clears glitch_cnt   (DEBOUNCE_GLITCH_CNT_EN only)
//     glitch_cnt  out  8         rejected-transition count, saturating at 255
//                                (DEBOUNCE_GLITCH_CNT_EN only)
// -----------------------------------------------------------------------------
module debounce_filter #(
    parameter int CHANNELS    = 4,
    parameter int DEPTH       = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] sig_in,
    input  logic                sample_en,
    output logic [CHANNELS-1:0] sig_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    input  logic                glitch_clr,
    output logic [7:0]          glitch_cnt
`endif
);

    // The counter must hold values 0..DEPTH-1.
    // A change is accepted on the sample that would otherwise bring it to DEPTH.
    localparam int            CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [CHANNELS-1:0] glitch_evt;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi = gi + 1) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [SYNC_STAGES:0]   sync_shift;
            logic                   s;
            logic [CW-1:0]          cnt_reg;
            logic [CW-1:0]          cnt_next;
            logic                   out_reg;
            logic                   out_next;
            logic                   rise_reg;
            logic                   rise_next;
            logic                   fall_reg;
            logic                   fall_next;

            // The shift is built one bit wider so that SYNC_STAGES=1 needs no
            // special-case slice.
            assign sync_shift = {sync_reg, sig_in[gi]};
            assign s          = sync_reg[SYNC_STAGES-1];

            // The synchroniser runs every clock, whatever sample_en is.
            always_ff @(posedge clock) begin
                if (!reset) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= sync_shift[SYNC_STAGES-1:0];
                end
            end

            always_comb begin
                cnt_next  = cnt_reg;
                out_next  = out_reg;
                rise_next = 1'b0;
                fall_next = 1'b0;
                if (sample_en) begin
                    if (s == out_reg) begin
                        // The matching level restarts the run; nothing is carried over.
                        cnt_next = '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        cnt_next  = '0;
                        out_next  = s;
                        rise_next = s;
                        fall_next = ~s;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end

            always_ff @(posedge clock) begin
                if (!reset) begin
                    cnt_reg  <= '0;
                    out_reg  <= 1'b0;
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                end else begin
                    cnt_reg  <= cnt_next;
                    out_reg  <= out_next;
                    rise_reg <= rise_next;
                    fall_reg <= fall_next;
                end
            end

            assign sig_out[gi] = out_reg;
            assign rise[gi]    = rise_reg;
            assign fall[gi]    = fall_reg;

`ifdef DEBOUNCE_GLITCH_CNT_EN
            // A glitch is a partial run that the matching level cut short.
            assign glitch_evt[gi] = sample_en && (s == out_reg) && (cnt_reg != '0);
`endif
        end
    endgenerate

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // With at most 32 channels the per-cycle sum fits in 6 bits.
    // Adding it to the 8-bit count needs at most 9 bits.
    logic [5:0] glitch_sum;
    logic [8:0] glitch_total;
    logic [7:0] glitch_cnt_reg;
    logic [7:0] glitch_cnt_next;

    always_comb begin
        glitch_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            glitch_sum = glitch_sum + {5'b0, glitch_evt[i]};
        end
    end

    always_comb begin
        glitch_total    = {1'b0, glitch_cnt_reg} + {3'b0, glitch_sum};
        glitch_cnt_next = glitch_total[7:0];
        if (glitch_total > 9'd255) begin
            glitch_cnt_next = 8'hFF;
        end
        // A clear on the same edge as new glitches wins.
        if (glitch_clr) begin
            glitch_cnt_next = 8'h00;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            glitch_cnt_reg <= 8'h00;
        end else begin
            glitch_cnt_reg <= glitch_cnt_next;
        end
    end

    assign glitch_cnt = glitch_cnt_reg;
`endif

endmodule

// File: tb/tb_debounce_filter.sv
// -----------------------------------------------------------------------------
// tb_debounce_filter
//
// Directed testbench for debounce_filter at its default parameters.
//
// A behavioural model checks the DUT outputs one time unit after every
// rising edge:
//     - The synchroniser is modelled as a delay queue.
//     - Acceptance is decided from the history of the last DEPTH qualified
//       samples.
//     - A glitch is a matching sample whose previous qualified sample did not
//       match.
// Literal checks in the stimulus pin the key timings by hand.
// -----------------------------------------------------------------------------
module tb_debounce_filter;

    localparam int CH    = 4;
    localparam int DEPTH = 3;
    localparam int SYNC  = 2;

    logic          clock;
    logic          reset;
    logic [CH-1:0] sig_in;
    logic          sample_en;
    logic [CH-1:0] sig_out;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic          glitch_clr;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0]    glitch_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    debounce_filter #(
        .CHANNELS   (CH),
        .DEPTH      (DEPTH),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .sig_in    (sig_in),
        .sample_en (sample_en),
        .sig_out   (sig_out),
        .rise      (rise),
        .fall      (fall)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_clr(glitch_clr),
        .glitch_cnt(glitch_cnt)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    logic [CH-1:0] sync_q[$];   // inputs captured but not yet visible as s
    logic [CH-1:0] samp_q[$];   // recent qualified samples, oldest first
    logic [CH-1:0] m_out  = '0;
    logic [CH-1:0] m_rise = '0;
    logic [CH-1:0] m_fall = '0;
    int            m_gcnt = 0;

    always @(posedge clock) begin
        logic [CH-1:0] s;
        logic [CH-1:0] e;
        int            n;
        bit            all_diff;
        if (!reset) begin
            sync_q = {};
            for (int k = 0; k < SYNC; k++) sync_q.push_back('0);
            samp_q = {};
            m_out  = '0;
            m_rise = '0;
            m_fall = '0;
            m_gcnt = 0;
        end else begin
            s = sync_q.pop_front();
            sync_q.push_back(sig_in);
            m_rise = '0;
            m_fall = '0;
            n = 0;
            if (sample_en) begin
                samp_q.push_back(s);
                if (samp_q.size() > DEPTH + 1) void'(samp_q.pop_front());
                for (int ch = 0; ch < CH; ch++) begin
                    if (s[ch] == m_out[ch]) begin
                        if (samp_q.size() >= 2) begin
                            e = samp_q[samp_q.size() - 2];
                            if (e[ch] != m_out[ch]) n++;
                        end
                    end else if (samp_q.size() >= DEPTH) begin
                        all_diff = 1'b1;
                        for (int k = 0; k < DEPTH; k++) begin
                            e = samp_q[samp_q.size() - 1 - k];
                            if (e[ch] == m_out[ch]) all_diff = 1'b0;
                        end
                        if (all_diff) begin
                            m_out[ch] = s[ch];
                            if (s[ch]) m_rise[ch] = 1'b1;
                            else       m_fall[ch] = 1'b1;
                        end
                    end
                end
            end
            if (glitch_clr)            m_gcnt = 0;
            else if (m_gcnt + n > 255) m_gcnt = 255;
            else                       m_gcnt = m_gcnt + n;
        end
        #1;
        vectors++;
        if (sig_out !== m_out || rise !== m_rise || fall !== m_fall
`ifdef DEBOUNCE_GLITCH_CNT_EN
            || glitch_cnt !== 8'(m_gcnt)
`endif
           ) begin
            miscompares++;
            $display("FAIL model t=%0t: sig_out=%h rise=%h fall=%h, required sig_out=%h rise=%h fall=%h gcnt=%0d",
                     $time, sig_out, rise, fall, m_out, m_rise, m_fall, m_gcnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    bit strobe_mode = 0;
    int phase       = 0;

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            if (strobe_mode) begin
                sample_en = (phase == 0);
                phase     = (phase + 1) % 4;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        sig_in = '0;
        step(2);
        reset  = 1'b1;
    endtask

    task automatic burst();
        sig_in = 4'hF;
        step(2);
        sig_in = 4'h0;
        step(4);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset      = 1'b0;
        sig_in     = 4'hF;
        sample_en  = 1'b1;
        glitch_clr = 1'b0;

        // Reset with all inputs high, then release: the outputs follow at edge 5.
        step(2);
        check("reset_sig_out", 32'(sig_out), 32'h0);
        check("reset_rise", 32'(rise), 32'h0);
        reset = 1'b1;
        step(4);
        check("rst_edge4_out", 32'(sig_out), 32'h0);
        step(1);
        check("rst_edge5_out", 32'(sig_out), 32'hF);
        check("rst_edge5_rise", 32'(rise), 32'hF);
        step(1);
        check("rst_edge6_rise", 32'(rise), 32'h0);

        // A 2-clock pulse on ch0 is rejected.
        do_reset();
        sig_in = 4'h1;
        step(2);
        sig_in = 4'h0;
        step(8);
        check("short_pulse_out", 32'(sig_out), 32'h0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("short_pulse_gcnt", 32'(glitch_cnt), 32'd1);
`endif

        // A 10-clock pulse on ch1: rise at edge 5, fall 5 edges after the input drops.
        do_reset();
        sig_in = 4'h2;
        step(4);
        check("ch1_edge4_out", 32'(sig_out), 32'h0);
        step(1);
        check("ch1_edge5_out", 32'(sig_out), 32'h2);
        check("ch1_edge5_rise", 32'(rise), 32'h2);
        step(5);
        sig_in = 4'h0;
        step(4);
        check("ch1_hold_out", 32'(sig_out), 32'h2);
        step(1);
        check("ch1_fall_out", 32'(sig_out), 32'h0);
        check("ch1_fall", 32'(fall), 32'h2);

        // Strobe every 4th clock: an 8-clock pulse is rejected, a 16-clock pulse is accepted.
        do_reset();
        strobe_mode = 1;
        phase       = 0;
        sig_in = 4'h4;
        step(8);
        sig_in = 4'h0;
        step(30);
        check("strobe8_out", 32'(sig_out), 32'h0);
        sig_in = 4'h4;
        step(16);
        check("strobe16_out", 32'(sig_out), 32'h4);
        sig_in = 4'h0;
        step(30);
        check("strobe16_back", 32'(sig_out), 32'h0);
        strobe_mode = 0;
        sample_en   = 1'b1;

        // Simultaneous glitch bursts on all channels: the count saturates, then a clear wins.
        do_reset();
        repeat (10) burst();
        check("burst_out", 32'(sig_out), 32'h0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("gcnt_10_bursts", 32'(glitch_cnt), 32'd40);
`endif
        repeat (54) burst();
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("gcnt_saturate", 32'(glitch_cnt), 32'd255);
`endif
        sig_in = 4'hF;
        step(2);
        sig_in = 4'h0;
        step(2);
        glitch_clr = 1'b1;
        step(1);
        glitch_clr = 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("gcnt_clr_wins", 32'(glitch_cnt), 32'd0);
`endif
        step(1);
        burst();
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("gcnt_after_clr", 32'(glitch_cnt), 32'd4);
`endif

        // Reset in the middle of a ch3 count: no event, and a full run is needed afterwards.
        do_reset();
        sig_in = 4'h8;
        step(4);
        reset = 1'b0;
        step(1);
        check("midrst_out", 32'(sig_out), 32'h0);
        check("midrst_evt", 32'(rise | fall), 32'h0);
        reset = 1'b1;
        step(4);
        check("midrst_edge4", 32'(sig_out), 32'h0);
        step(1);
        check("midrst_edge5", 32'(sig_out), 32'h8);
        check("midrst_rise", 32'(rise), 32'h8);
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
